bcd_to_binary: RTL and testbench

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

---
 rtl/bcd_to_binary.sv | 83 ++++++++
 tb/tb_bcd_to_binary.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential 3-digit BCD to 10-bit binary converter (reverse double dabble).
// Ports: clk, rst_n (sync, active-low), start/bcd[11:0] request, binary[9:0] result,
// busy (conversion in progress), done (one-cycle result-valid pulse), error (invalid digit).
// Optional: define BCD_DIGIT_CHECK_EN to reject digits > 9 with error=1 and a short path.
module bcd_to_binary (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] bcd,
  output logic [9:0]  binary,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [21:0] work_q, work_d, sh;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] binary_q, binary_d;
  logic bad_q, bad_d, bad_in, done_q, done_d, error_q, error_d;
  function automatic logic [3:0] fix(input logic [3:0] d);
    return d >= 4'd8 ? d - 4'd3 : d;
  endfunction
`ifdef BCD_DIGIT_CHECK_EN
  assign bad_in = (bcd[11:8] > 4'd9) | (bcd[7:4] > 4'd9) | (bcd[3:0] > 4'd9);
`else
  assign bad_in = 1'b0;
`endif
  // Each digit field is corrected after the shift so it stays a valid halved BCD digit.
  assign sh = {1'b0, work_q[21:1]};
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    binary_d = binary_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cnt_d   = 4'd0;
        bad_d   = bad_in;
        work_d  = bad_in ? 22'd0 : {bcd, 10'd0};
        state_d = bad_in ? DONE : SHIFT;
      end
      SHIFT: begin
        work_d  = {fix(sh[21:18]), fix(sh[17:14]), fix(sh[13:10]), sh[9:0]};
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'd9 ? DONE : SHIFT;
      end
      DONE: begin
        binary_d = work_q[9:0];
        error_d  = bad_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= 22'd0;
      cnt_q    <= 4'd0;
      bad_q    <= 1'b0;
      binary_q <= 10'd0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      binary_q <= binary_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign binary = binary_q;
  assign done   = done_q;
  assign error  = error_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed self-checking bench for bcd_to_binary.
module tb_bcd_to_binary;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [11:0] bcd = 12'd0;
  logic [9:0] binary;
  logic busy, done, error;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  bcd_to_binary dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
    .binary(binary), .busy(busy), .done(done), .error(error)
  );

  // Pulse start for one edge, then count cycles until done (bounded) and busy cycles seen.
  task automatic run(input logic [11:0] v, output int lat, output int nb);
    start = 1'b1;
    bcd = v;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    nb = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nb++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (binary !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: binary=%0d busy=%b done=%b error=%b, required 0/0/0/0", binary, busy, done, error);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_values();
    logic [11:0] vin [6] = '{12'h000, 12'h001, 12'h511, 12'h512, 12'h100, 12'h999};
    int exp [6] = '{0, 1, 511, 512, 100, 999};
    int lat, nb;
    for (int i = 0; i < 6; i++) begin
      run(vin[i], lat, nb);
      vectors++;
      if (lat != 11 || binary !== exp[i][9:0] || error !== 1'b0) begin
        miscompares++;
        $display("FAIL value %h: lat=%0d binary=%0d error=%b, required lat=11 binary=%0d error=0", vin[i], lat, binary, error, exp[i]);
      end
      vectors++;
      if (nb != 11) begin
        miscompares++;
        $display("FAIL busy_len %h: busy cycles=%0d, required 11", vin[i], nb);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || binary !== exp[i][9:0] || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL hold %h: done=%b binary=%0d busy=%b, required done=0 binary=%0d busy=0", vin[i], done, binary, busy, exp[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int lat, nb;
    logic [3:0] h, t, u;
    for (int i = 0; i < 1000; i++) begin
      h = 4'(i / 100);
      t = 4'((i / 10) % 10);
      u = 4'(i % 10);
      run({h, t, u}, lat, nb);
      vectors++;
      if (lat != 11 || binary !== 10'(i) || error !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep %0d: lat=%0d binary=%0d error=%b, required lat=11 binary=%0d error=0", i, lat, binary, error, i);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    logic [9:0] got = 10'd0;
    start = 1'b1;
    bcd = 12'h456;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    bcd = 12'h123;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; got = binary; end
    end
    vectors++;
    if (ndone != 1 || got !== 10'd456) begin
      miscompares++;
      $display("FAIL busy_ignore: done pulses=%0d binary=%0d, required 1 pulse binary=456", ndone, got);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb;
    start = 1'b1;
    bcd = 12'h777;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || binary !== 10'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b binary=%0d done=%b, required 0/0/0", busy, binary, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(12'h042, lat, nb);
    vectors++;
    if (lat != 11 || binary !== 10'd42) begin
      miscompares++;
      $display("FAIL reset_recover: lat=%0d binary=%0d, required lat=11 binary=42", lat, binary);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vin [4] = '{12'h250, 12'h007, 12'h864, 12'h300};
    int exp [4] = '{250, 7, 864, 300};
    int lat;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bcd = vin[k];
      @(posedge clk); #1;
      bcd = 12'hfff - vin[k];
      lat = 0;
      while (!done && lat < 30) begin @(posedge clk); #1; lat++; end
      vectors++;
      if (lat != 11 || binary !== exp[k][9:0]) begin
        miscompares++;
        $display("FAIL back_to_back %0d: lat=%0d binary=%0d, required lat=11 binary=%0d", k, lat, binary, exp[k]);
      end
    end
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_digit_check();
    int lat, nb;
    run(12'h1A3, lat, nb);
`ifdef BCD_DIGIT_CHECK_EN
    vectors++;
    if (lat != 1 || error !== 1'b1 || binary !== 10'd0) begin
      miscompares++;
      $display("FAIL digit_bad: lat=%0d error=%b binary=%0d, required lat=1 error=1 binary=0", lat, error, binary);
    end
`else
    vectors++;
    if (lat != 11 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL digit_nocheck: lat=%0d error=%b, required lat=11 error=0", lat, error);
    end
`endif
    run(12'h123, lat, nb);
    vectors++;
    if (lat != 11 || error !== 1'b0 || binary !== 10'd123) begin
      miscompares++;
      $display("FAIL digit_good: lat=%0d error=%b binary=%0d, required lat=11 error=0 binary=123", lat, error, binary);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_values();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_digit_check();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
